// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory request/response channel
// and the decode-side instruction handshake.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_misalign;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_misalign,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_misalign,
      output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests to instruction
// memory, PC-tagged response buffering, and flush of all in-flight fetches.
module fetch_unit #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  pc,
   output logic         pc_en,
   input  logic         flush,
   fetch_unit_if.master bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   cnt_t out_cnt_q, out_cnt_d;
   cnt_t drop_cnt_q, drop_cnt_d;
   cnt_t occ_q, occ_d;
   ptr_t tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   ptr_t ins_wr_q, ins_wr_d, ins_rd_q, ins_rd_d;

   logic [31:0] tag_mem      [DEPTH];
   logic [31:0] ins_pc_mem   [DEPTH];
   logic [31:0] ins_word_mem [DEPTH];

   logic [CW:0] used;
   logic        fire, resp, keep, pop;

   // Credit is judged on registered counts only, so no response or decode
   // activity can reach the request/PC-enable outputs combinationally.
   always_comb begin
      used               = {1'b0, out_cnt_q} + {1'b0, occ_q};
      bus.imem_req_valid = rst_n && !flush && (used < (CW+1)'(DEPTH));
      fire               = bus.imem_req_valid && bus.imem_req_ready;
      pc_en              = rst_n && (fire || flush);
      resp               = bus.imem_resp_valid && (out_cnt_q != '0);
      keep               = resp && (drop_cnt_q == '0) && !flush;
      pop                = bus.inst_valid && bus.inst_ready && !flush;
   end

   // NOTE: every next-state signal gets its value on every path through the
   // block, which keeps this purely combinational and free of latches.
   always_comb begin
      out_cnt_d  = out_cnt_q + cnt_t'(fire) - cnt_t'(resp);
      drop_cnt_d = drop_cnt_q;
      tag_wr_d   = tag_wr_q + ptr_t'(fire);
      tag_rd_d   = tag_rd_q + ptr_t'(resp);
      occ_d      = occ_q + cnt_t'(keep) - cnt_t'(pop);
      ins_wr_d   = ins_wr_q + ptr_t'(keep);
      ins_rd_d   = ins_rd_q + ptr_t'(pop);
      if (flush) begin
         // Every request still outstanding after this cycle is stale.
         drop_cnt_d = out_cnt_q - cnt_t'(resp);
         occ_d      = '0;
         ins_wr_d   = '0;
         ins_rd_d   = '0;
      end else if (resp && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - cnt_t'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so each flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         occ_q      <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         ins_wr_q   <= '0;
         ins_rd_q   <= '0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         occ_q      <= occ_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         ins_wr_q   <= ins_wr_d;
         ins_rd_q   <= ins_rd_d;
      end
   end

   // NOTE: the storage arrays are not reset; occupancy and pointers decide what
   // is valid, and the outputs are masked to zero whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (fire) begin
         tag_mem[tag_wr_q] <= pc;
      end
      if (keep) begin
         ins_pc_mem[ins_wr_q]   <= tag_mem[tag_rd_q];
         ins_word_mem[ins_wr_q] <= bus.imem_resp_data;
      end
   end

   assign bus.imem_req_addr = {pc[31:2], 2'b00};
   assign bus.inst_valid    = (occ_q != '0);
   assign bus.inst          = bus.inst_valid ? ins_word_mem[ins_rd_q] : '0;
   assign bus.inst_pc       = bus.inst_valid ? ins_pc_mem[ins_rd_q]   : '0;
   assign bus.inst_misalign = (bus.inst_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: PC register and fixed-latency memory models,
// expected {pc, word} pushed on each accepted request and compared at decode.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        pc_en;
   logic [31:0] pc;
   logic [31:0] target;

   fetch_unit_if bus ();

   fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pc    (pc),
      .pc_en (pc_en),
      .flush (flush),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_bad    = 0;

   mreq_t memq [$];
   exp_t  exp_q [$];
   exp_t  e;
   int    cyc = 0;
   int    lat = 1;
   int    m_occ = 0;
   int    m_stale = 0;
   int    n_fire = 0;
   int    n_pop = 0;
   int    first_fire = -1;
   int    first_valid = -1;
   bit    m_fire, m_pop, hold_prev, found;
   logic [31:0] prev_inst, prev_pc, last_pop_pc;
   logic        last_pop_mis;
   int    p0, f0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {~a[15:0], a[17:2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timed out");
   end

   // PC register: reset vector, loads next PC or redirect target on pc_en.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)     pc <= 32'h0040_0000;
      else if (pc_en) pc <= flush ? target : pc + 32'd4;
   end

   // Instruction memory: in-order responses lat cycles after acceptance.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1;
      if (rst_n && memq.size() != 0 && memq[0].due <= cyc) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = word_of(memq[0].addr);
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = '0;
      end
   end

   // Monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         memq.delete();
         exp_q.delete();
         m_occ       = 0;
         m_stale     = 0;
         hold_prev   = 1'b0;
         first_fire  = -1;
         first_valid = -1;
      end else begin
         m_fire = bus.imem_req_valid && bus.imem_req_ready;
         m_pop  = bus.inst_valid && bus.inst_ready && !flush;
         check("req_valid", 32'(bus.imem_req_valid),
               32'(!flush && (memq.size() + m_occ < DEPTH)));
         check("pc_en", 32'(pc_en), 32'(m_fire || flush));
         check("inst_valid", 32'(bus.inst_valid), 32'(m_occ != 0));
         if (bus.imem_req_valid)
            check("req_addr", bus.imem_req_addr, {pc[31:2], 2'b00});
         if (hold_prev) begin
            check("hold_inst", bus.inst, prev_inst);
            check("hold_pc", bus.inst_pc, prev_pc);
         end
         if (m_pop) begin
            check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_pc", bus.inst_pc, e.pc);
               check("sb_inst", bus.inst, e.word);
               check("sb_misalign", 32'(bus.inst_misalign), 32'(e.pc[1:0] != 2'b00));
            end
            n_pop++;
            last_pop_pc  = bus.inst_pc;
            last_pop_mis = bus.inst_misalign;
         end
         if (bus.imem_resp_valid && memq.size() != 0) begin
            memq.delete(0);
            if (m_stale > 0)  m_stale--;
            else if (!flush)  m_occ++;
         end
         if (m_pop) m_occ--;
         if (flush) begin
            m_occ   = 0;
            m_stale = memq.size();
            exp_q.delete();
         end
         if (m_fire) begin
            memq.push_back('{bus.imem_req_addr, cyc + lat});
            exp_q.push_back('{pc, word_of({pc[31:2], 2'b00})});
            n_fire++;
            if (first_fire < 0) first_fire = cyc;
         end
         if (bus.inst_valid && first_valid < 0) first_valid = cyc;
         hold_prev = bus.inst_valid && !bus.inst_ready && !flush;
         prev_inst = bus.inst;
         prev_pc   = bus.inst_pc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
      int  base;
      bit  got;
      base = n_pop;
      got  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (n_pop != base) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_seen"}, 32'(got), 32'd1);
      if (got) check({tag, "_pc"}, last_pop_pc, exp_pc);
   endtask

   initial begin
      rst_n  = 1'b0;
      flush  = 1'b0;
      target = '0;
      lat    = 1;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;

      // Outputs while held in reset.
      #3;
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      check("rst_misalign", 32'(bus.inst_misalign), 32'd0);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_pc_en", 32'(pc_en), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("rel_req_addr", bus.imem_req_addr, 32'h0040_0000);

      // Streaming with L=1 and decode always ready.
      repeat (10) tick();
      p0 = n_pop;
      repeat (10) tick();
      check("throughput", 32'(n_pop - p0), 32'd10);
      check("first_latency", 32'(first_valid - first_fire), 32'd2);

      // Decode stalled from reset release: exactly DEPTH requests go out.
      bus.inst_ready = 1'b0;
      do_reset();
      f0 = n_fire;
      repeat (10) tick();
      check("stall_fires", 32'(n_fire - f0), 32'd4);
      check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("stall_pc_en", 32'(pc_en), 32'd0);
      bus.inst_ready = 1'b1;
      p0 = n_pop;
      repeat (6) tick();
      check("stall_drain", 32'(n_pop - p0 >= 4), 32'd1);

      // Request-ready toggling, then random backpressure.
      p0 = n_pop;
      for (int i = 0; i < 40; i++) begin
         bus.imem_req_ready = (i < 20) ? (i % 2 == 1) : 1'($urandom_range(0, 1));
         tick();
      end
      bus.imem_req_ready = 1'b1;
      check("toggle_flow", 32'(n_pop - p0 > 8), 32'd1);

      // Flush with two outstanding and one buffered, L=3.
      lat = 3;
      bus.inst_ready     = 1'b0;
      bus.imem_req_ready = 1'b1;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (memq.size() == 2 && m_occ == 1) found = 1'b1;
         else begin
            bus.imem_req_ready = (memq.size() + m_occ < 3);
            tick();
         end
      end
      check("flush_setup", 32'(found), 32'd1);
      target = 32'h0000_1000;
      flush  = 1'b1;
      bus.imem_req_ready = 1'b1;
      #1;
      check("flush_pc_en", 32'(pc_en), 32'd1);
      check("flush_req_valid", 32'(bus.imem_req_valid), 32'd0);
      tick();
      flush = 1'b0;
      check("flush_emptied", 32'(bus.inst_valid), 32'd0);
      bus.inst_ready = 1'b1;
      wait_pop("redirect", 32'h0000_1000);

      // Flush coinciding with a response, then a second flush one cycle later.
      lat = 2;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus.imem_resp_valid) found = 1'b1;
      end
      check("resp_seen", 32'(found), 32'd1);
      target = 32'h0000_2000;
      flush  = 1'b1;
      tick();
      target = 32'h0000_3000;
      tick();
      flush = 1'b0;
      wait_pop("double_flush", 32'h0000_3000);
      repeat (8) tick();
      check("drop_cnt_zero", 32'(dut.drop_cnt_q), 32'd0);

      // Misaligned redirect target.
      target = 32'h0040_0002;
      flush  = 1'b1;
      tick();
      flush = 1'b0;
      wait_pop("misalign", 32'h0040_0002);
      check("misalign_flag", 32'(last_pop_mis), 32'd1);

      // Asynchronous reset in the middle of the stream.
      repeat (5) tick();
      check("pre_rst_valid", 32'(bus.inst_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("async_pc_en", 32'(pc_en), 32'd0);
      check("async_inst", bus.inst, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_pop("after_reset", 32'h0040_0000);
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end sitting between the program-counter register and instruction memory. It consumes the current `pc` and issues in-order read requests to instruction memory over a valid/ready handshake. It advances the PC register through `pc_en`, buffers returned words with their PCs in a small FIFO, and hands them to decode over a second valid/ready handshake. A `flush` input discards every in-flight and buffered fetch on a redirect.

## Interface
- `DEPTH`, 4: combined limit on outstanding requests plus buffered instructions; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC from the PC register (reset value 0x0040_0000).
- `pc_en`  out  1  enable to the PC register; PC loads `npc` when high.
- `flush`  in  1  redirect; kills all older fetches this cycle.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word address, `{pc[31:2],2'b00}`.
- `imem_resp_valid`  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance, at most one per cycle.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `inst_misalign`  out  1  `inst_pc[1:0]!=0`; the word is still delivered.

## Operation
- State: `out_cnt` (accepted, unanswered requests), PC-tag FIFO (DEPTH entries, tag = pc of each accepted request), instruction FIFO (DEPTH entries of {pc, word}), `drop_cnt`.
- Credit: `imem_req_valid = !flush && (out_cnt + occupancy < DEPTH)`, using registered values only; a same-cycle pop or response does not free credit.
- Fire = `imem_req_valid && imem_req_ready`. On fire, push `pc` into the tag FIFO and increment `out_cnt`.
- `pc_en = fire || flush`. The PC advances only on an accepted request or on redirect.
- Response with `drop_cnt==0`: pop the tag and write {tag, data} into the instruction FIFO. `out_cnt` decrements.
- Response with `drop_cnt>0`: discard it, pop the tag, and decrement both `drop_cnt` and `out_cnt`.
- Decode handshake: pop on `inst_valid && inst_ready`. `inst`, `inst_pc` and `inst_misalign` come from the FIFO head and stay stable while valid and not ready.
- Flush cycle:
  - The instruction FIFO is cleared.
  - A response arriving this cycle is discarded.
  - `drop_cnt <= out_cnt - resp_this_cycle` (every outstanding request is stale).
  - No request is issued.
  - A flush while `drop_cnt>0` uses the same rule; `out_cnt` already includes the earlier stale requests.
- Counter widths: `$clog2(DEPTH)+1` bits. `out_cnt` never exceeds DEPTH by construction. A response with `out_cnt==0` is a protocol error: ignored, counters unchanged.

## Timing
- Reset (async assert, sync release):
  - `out_cnt=0`, `drop_cnt=0`, both FIFOs empty.
  - `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_misalign=0`.
  - `imem_req_valid` and `pc_en` are forced 0 while `rst_n=0`.
  - First cycle after release: `imem_req_valid=1`.
- Reset mid-operation drops all state. Late memory responses after release are the system's responsibility; memory is reset with the core.
- Latency: request accepted in cycle N, response at N+L, `inst_valid` at N+L+1.
- Throughput is one instruction per cycle when `DEPTH ≥ L+2` and decode is always ready.
- `imem_req_valid` and `pc_en` are combinational from registered state, `flush` and `imem_req_ready`. There is no path from `imem_resp_*` or `inst_ready` to them.
- Simultaneous response and pop: both take effect; occupancy is unchanged.
- Full case (`out_cnt + occupancy == DEPTH`): `imem_req_valid=0` and `pc_en=0`, so the PC holds.

## Test plan
- Reset release, memory L=1, decode always ready → requests go out at 0x0040_0000, _04, _08…; first `inst_valid` 2 cycles after the first fire; then one instruction per cycle with `inst_pc` matching.
- Decode stalled (`inst_ready=0`) for 10 cycles, L=1 → exactly 4 requests issue, then `pc_en=0` and `imem_req_valid=0` hold. `inst`/`inst_pc` stay stable. After release, the 4 words drain in order.
- `imem_req_ready` toggling 1/0 → `pc_en` equals fire each cycle; no PC skipped or duplicated in the `inst_pc` stream.
- Flush with 2 outstanding and 1 buffered, L=3 → buffer empties that cycle with `pc_en=1` and `imem_req_valid=0`. The next 2 responses are dropped. The first delivered `inst_pc` equals the redirect target.
- Flush coinciding with a response, followed by a second flush 1 cycle later → every stale response is dropped, `drop_cnt` returns to 0, and no stale `inst_pc` reaches decode.
- `pc`=0x0040_0002 → `imem_req_addr`=0x0040_0000 and `inst_misalign=1` with `inst_pc`=0x0040_0002. Asserting `rst_n=0` mid-stream → `inst_valid` drops immediately (asynchronously).
